// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes packed instructions into ALU/regfile controls and returns result records
module alu_sequencer #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [8:0]        in_instr,
    output logic              in_ready,
    output logic [2:0]        alu_control,
    output logic [1:0]        addr1,
    output logic [1:0]        addr2,
    output logic [1:0]        addr3,
    output logic              wr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              overflow,
    input  logic              carry,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_ovf,
    output logic              out_carry,
    input  logic              out_ready,
    output logic              halted,
    input  logic              clr_halt,
    output logic [CNT_W-1:0]  instr_count
);
    typedef enum logic [2:0] {IDLE, EXEC, COMMIT, RESP, HALT} state_t;
    state_t state_q, state_d;
    logic [2:0] ctl_q, ctl_d;
    logic [1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic ovf_q, ovf_d, car_q, car_d, vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic stop;
    assign stop = STOP_ON_OVF && overflow;
    // next-state, instruction latch, result capture and retire counting
    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        car_d   = car_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = EXEC;
                ctl_d   = in_instr[8:6];
                a3_d    = in_instr[5:4];
                a1_d    = in_instr[3:2];
                a2_d    = in_instr[1:0];
            end
            EXEC: begin
                res_d   = alu_result;
                ovf_d   = overflow;
                car_d   = carry;
                vld_d   = stop;
                state_d = stop ? HALT : COMMIT;
            end
            COMMIT: begin
                vld_d   = 1'b1;
                state_d = RESP;
            end
            RESP: if (out_ready) begin
                vld_d   = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end
            HALT: begin
                vld_d   = vld_q && !out_ready;
                cnt_d   = (vld_q && out_ready) ? cnt_q + 1'b1 : cnt_q;
                state_d = (clr_halt && (!vld_q || out_ready)) ? IDLE : HALT;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctl_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            car_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            car_q   <= car_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end
    // a reset landing on the COMMIT cycle aborts the write on that same edge
    assign wr          = (state_q == COMMIT) && !rst;
    assign in_ready    = state_q == IDLE;
    assign halted      = state_q == HALT;
    assign alu_control = ctl_q;
    assign addr1       = a1_q;
    assign addr2       = a2_q;
    assign addr3       = a3_q;
    assign out_valid   = vld_q;
    assign out_result  = res_q;
    assign out_ovf     = ovf_q;
    assign out_carry   = car_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed checks of alu_sequencer against a transaction-level model
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, clr_halt = 1'b0;
    logic [8:0] in_instr = '0;
    logic in_ready, wr, overflow, carry, out_valid, out_ovf, out_carry, halted;
    logic [2:0] alu_control;
    logic [1:0] addr1, addr2, addr3;
    logic [31:0] alu_result, out_result;
    logic [7:0] instr_count;
    logic pl_en = 1'b0;
    logic [1:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] rf [4];
    logic [33:0] dp;
    int vectors = 0, miscompares = 0;
    bit chk_en = 0, wrap_seen = 0;
    logic [7:0] last_cnt = '0;
    logic [31:0] gold [4] = '{default: 32'd0};
    bit m_busy = 0, m_halt = 0, m_pend = 0, m_ovf = 0, m_car = 0;
    int m_age = 0;
    logic [7:0] m_cnt = '0;
    logic [31:0] m_res = '0;
    logic [2:0] m_ctl = '0;
    logic [1:0] m_a1 = '0, m_a2 = '0, m_a3 = '0;
    logic [33:0] m_t = '0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(32), .CNT_W(8), .STOP_ON_OVF(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_control(alu_control), .addr1(addr1), .addr2(addr2), .addr3(addr3), .wr(wr),
        .alu_result(alu_result), .overflow(overflow), .carry(carry),
        .out_valid(out_valid), .out_result(out_result), .out_ovf(out_ovf), .out_carry(out_carry),
        .out_ready(out_ready), .halted(halted), .clr_halt(clr_halt), .instr_count(instr_count));

    function automatic logic [33:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic o;
        s = '0;
        o = 1'b0;
        r = a;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = a;
        endcase
        return {o, s[32], r};
    endfunction

    always_comb dp = alu_ref(alu_control, rf[addr1], rf[addr2]);
    assign {overflow, carry, alu_result} = dp;

    always @(posedge clk) begin
        if (wr) rf[addr3] <= alu_result;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic check();
        if (!chk_en) return;
        chk("in_ready", 64'(in_ready), 64'(!m_busy && !m_halt));
        chk("wr", 64'(wr), 64'(m_busy && m_age == 2 && !rst));
        chk("out_valid", 64'(out_valid), 64'(m_pend));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("instr_count", 64'(instr_count), 64'(m_cnt));
        chk("out_result", 64'(out_result), 64'(m_res));
        chk("out_ovf", 64'(out_ovf), 64'(m_ovf));
        chk("out_carry", 64'(out_carry), 64'(m_car));
        chk("ctl_addr", 64'({alu_control, addr1, addr2, addr3}), 64'({m_ctl, m_a1, m_a2, m_a3}));
        for (int i = 0; i < 4; i++) chk("regfile", 64'(rf[i]), 64'(gold[i]));
        if (last_cnt == 8'hFF && instr_count == 8'h00 && !rst) wrap_seen = 1;
        last_cnt = instr_count;
    endtask

    task automatic update();
        bit pend0;
        pend0 = m_pend;
        if (pl_en) gold[pl_addr] = pl_data;
        if (rst) begin
            m_busy = 0; m_halt = 0; m_pend = 0; m_age = 0; m_cnt = '0;
            m_res = '0; m_ovf = 0; m_car = 0; m_ctl = '0; m_a1 = '0; m_a2 = '0; m_a3 = '0;
        end else if (m_halt) begin
            if (pend0 && out_ready) begin m_pend = 0; m_cnt = m_cnt + 8'd1; end
            if (clr_halt && (!pend0 || out_ready)) m_halt = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_age = 1;
                {m_ctl, m_a3, m_a1, m_a2} = in_instr;
                m_t = alu_ref(m_ctl, gold[m_a1], gold[m_a2]);
            end
        end else if (m_age == 1) begin
            {m_ovf, m_car, m_res} = m_t;
            if (m_t[33]) begin m_busy = 0; m_halt = 1; m_pend = 1; end
            else m_age = 2;
        end else if (m_age == 2) begin
            gold[m_a3] = m_t[31:0];
            m_age = 3;
            m_pend = 1;
        end else if (out_ready) begin
            m_pend = 0;
            m_busy = 0;
            m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic step();
        #1;
        check();
        update();
        @(negedge clk);
    endtask

    task automatic preload(input logic [1:0] a, input logic [31:0] d);
        in_valid = 1'b0;
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clr_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pl_en = 1'b1;
            pl_addr = 2'(i);
            pl_data = '0;
            step();
        end
        pl_en = 1'b0;
        rst = 1'b0;
        chk_en = 1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(instr_count), 64'd0);
        chk("rst_ctl", 64'({alu_control, addr1, addr2, addr3, out_result}), 64'd0);

        preload(2'd1, 32'd3);
        preload(2'd2, 32'd4);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 9'b000_11_01_10;
        step();
        in_instr = 9'b011_00_01_10;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_result", 64'(out_result), 64'd7);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        chk("basic_r3", 64'(rf[3]), 64'd7);
        chk("basic_ovf", 64'(out_ovf), 64'd0);
        out_ready = 1'b1;
        step();
        chk("basic_count", 64'(instr_count), 64'd1);
        chk("bp_second_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("second_r0", 64'(rf[0]), 64'd7);

        do_reset();
        preload(2'd1, 32'h7FFF_FFFF);
        preload(2'd2, 32'd1);
        preload(2'd3, 32'h55);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 9'b000_11_01_10;
        step();
        in_valid = 1'b0;
        step();
        #1;
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_ovf", 64'(out_ovf), 64'd1);
        chk("halt_result", 64'(out_result), 64'h8000_0000);
        chk("halt_valid", 64'(out_valid), 64'd1);
        clr_halt = 1'b1;
        step();
        chk("halt_pending_hold", 64'(halted), 64'd1);
        out_ready = 1'b1;
        step();
        clr_halt = 1'b0;
        chk("halt_left", 64'({halted, in_ready, out_valid}), 64'b010);
        chk("halt_r3", 64'(rf[3]), 64'h55);
        chk("halt_count", 64'(instr_count), 64'd1);

        preload(2'd1, 32'd5);
        preload(2'd2, 32'd2);
        in_valid = 1'b1;
        in_instr = 9'b000_01_01_10;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("alias_r1", 64'(rf[1]), 64'd7);
        chk("alias_result", 64'(out_result), 64'd7);
        step();

        preload(2'd0, 32'h99);
        in_valid = 1'b1;
        in_instr = 9'b001_00_01_10;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("abort_wr", 64'(wr), 64'd0);
        chk("abort_state", 64'({in_ready, out_valid, halted}), 64'b100);
        chk("abort_count", 64'(instr_count), 64'd0);
        chk("abort_ctl", 64'({alu_control, addr1, addr2, addr3, out_result}), 64'd0);
        chk("abort_r0", 64'(rf[0]), 64'h99);

        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom % 150) == 0;
            in_valid = ($urandom % 3) != 0;
            in_instr = 9'($urandom);
            out_ready = ($urandom % 4) != 0;
            clr_halt = ($urandom % 6) == 0;
            pl_en = !m_busy && !m_halt && ($urandom % 5) == 0;
            pl_addr = 2'($urandom);
            pl_data = ($urandom % 2) ? 32'h7FFF_FFF0 + ($urandom % 32) : $urandom;
            step();
        end
        pl_en = 1'b0;
        rst = 1'b0;
        clr_halt = 1'b0;

        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            in_instr = {3'(2 + $urandom % 3), 6'($urandom)};
            step();
            if (i == 39) chk("cadence_count", 64'(instr_count), 64'd10);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("wrap_seen", 64'(wrap_seen), 64'd1);
        chk("wrap_count", 64'(instr_count), 64'(8'(300)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
